// File: rtl/count_ctrl_pkg.sv
// Shared types and helpers for the count_load_arbiter block: FSM state
// encoding, default counter width and an elaboration-time log2 helper.
package count_ctrl_pkg;

  localparam int CNT_W_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Bits needed to index n items (n >= 2).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches for the next request starting just after the
// last completed winner. The pointer moves only when a job finishes.
module rr_arbiter
  import count_ctrl_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic            upd,
  input  logic [IW-1:0]   upd_id,
  output logic [IW-1:0]   grant_id,
  output logic            any
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] cand;
  logic          found;

  // Reset points at the last requester so req[0] has top priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IW'(NREQ - 1);
    end else if (upd) begin
      ptr_q <= upd_id;
    end
  end

  always_comb begin
    grant_id = '0;
    found    = 1'b0;
    cand     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(ptr_q) + i) % NREQ);
      if (!found && req[cand]) begin
        found    = 1'b1;
        grant_id = cand;
      end
    end
  end

  assign any = en & found;

endmodule

// File: rtl/count_load_arbiter.sv
// Shares one external loadable up-counter among NREQ requesters: grants one
// job at a time, loads its start value and reports done when the count wraps.
module count_load_arbiter
  import count_ctrl_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int CW   = CNT_W_DEFAULT,
  localparam int IW   = clog2(NREQ),
  localparam int VW   = clog2(NREQ * CW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*CW-1:0] req_val,
  output logic [NREQ-1:0]   gnt,
  output logic [IW-1:0]     gnt_id,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic              cnt_set,
  output logic [CW-1:0]     cnt_set_num,
  input  logic [CW-1:0]     cnt_number,
  input  logic              cnt_zero
);

  state_e state_q, state_d;

  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   gnt_id_q, gnt_id_d;
  logic [CW-1:0]   v_q, v_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic            cnt_set_q, cnt_set_d;

  logic [IW-1:0]   arb_id;
  logic            arb_any;
  logic            req_w;
  logic [VW-1:0]   val_base;

  // The requesters read the count themselves; only the zero flag sequences a job.
  logic cnt_number_unused;
  assign cnt_number_unused = ^cnt_number;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .en       (state_q == IDLE),
    .upd      (state_q == DONE),
    .upd_id   (gnt_id_q),
    .grant_id (arb_id),
    .any      (arb_any)
  );

  assign req_w    = req[gnt_id_q];
  assign val_base = VW'(int'(arb_id) * CW);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Dropping the granted request aborts from any active
  // state except DONE; cnt_zero is only trusted in RUN, since in SETTLE it
  // still reflects the counter's pre-load value.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves state_d
    // unassigned, which would infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arb_any) state_d = LOAD;
      LOAD:    state_d = req_w ? SETTLE : IDLE;
      SETTLE:  state_d = req_w ? RUN : IDLE;
      RUN: begin
        if (!req_w)        state_d = IDLE;
        else if (cnt_zero) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/next-register logic; outputs are decoded from state_d so every
  // port comes straight from a flop.
  always_comb begin
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    v_d      = v_q;
    if (state_q == IDLE && arb_any) begin
      gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << arb_id;
      gnt_id_d = arb_id;
      v_d      = req_val[val_base +: CW];
    end else if (state_d == IDLE) begin
      gnt_d    = '0;
    end
    busy_d    = (state_d != IDLE);
    cnt_set_d = (state_d == LOAD);
    done_d    = (state_d == DONE) ? gnt_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      v_q       <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      cnt_set_q <= 1'b0;
    end else begin
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      v_q       <= v_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      cnt_set_q <= cnt_set_d;
    end
  end

  assign gnt         = gnt_q;
  assign gnt_id      = gnt_id_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign cnt_set     = cnt_set_q;
  assign cnt_set_num = v_q;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
  a_set_in_load: assert property (@(posedge clk) disable iff (!rst_n)
                                  cnt_set_q |-> (state_q == LOAD));
  a_done_granted: assert property (@(posedge clk) disable iff (!rst_n)
                                   (done_q != '0) |-> (done_q == gnt_q));

endmodule
